// File: rtl/load_store_unit_if.sv
// Execute-side request, writeback-side response and word-wide memory bus of the load/store unit.
// The slave modport is the LSU itself; the master modport is everything around it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_err;

  modport slave (
    input  req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_ack, mem_rdata, resp_ready,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output resp_valid, resp_rd, resp_data, resp_err
  );

  modport master (
    output req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output mem_ack, mem_rdata, resp_ready,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  resp_valid, resp_rd, resp_data, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one aligned access per request on a req/ack word bus, with byte lanes,
// load extension, misalignment/illegal-width detection and an optional bus timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  typedef struct packed {
    logic       is_load;
    logic [2:0] funct3;
    logic [1:0] offset;
    logic [4:0] rd;
  } op_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_q, op_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        resp_valid_q, resp_valid_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        f3_legal;
  logic        misaligned;
  logic        bad;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign bus.req_ready  = (state_q == IDLE) & ~rst;
  assign accept         = bus.req_valid & bus.req_ready & (bus.req_is_load | bus.req_is_store);

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

  // Request decode: width legality, alignment and store lane placement.
  always_comb begin
    f3_legal    = 1'b0;
    store_be    = 4'hF;
    store_wdata = bus.req_wdata;
    if (bus.req_is_load) begin
      f3_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else begin
      f3_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    end
    misaligned = ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0]) |
                 ((bus.req_funct3[1:0] == 2'b10) & (bus.req_addr[1:0] != 2'b00));
    bad = ~f3_legal | misaligned;
    case (bus.req_funct3[1:0])
      2'b00: begin
        store_be    = 4'(4'b0001 << bus.req_addr[1:0]);
        store_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        store_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        store_be    = 4'hF;
        store_wdata = bus.req_wdata;
      end
    endcase
  end

  // Load lane extraction and extension from the captured width and byte offset.
  always_comb begin
    shifted = bus.mem_rdata >> {op_q.offset, 3'b000};
    case (op_q.funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h000000, shifted[7:0]};
      3'b101:  load_data = {16'h0000, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Next state and next registered outputs; everything holds unless a transition fires.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    resp_valid_d = resp_valid_q;
    resp_rd_d    = resp_rd_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d.is_load = bus.req_is_load;
          op_d.funct3  = bus.req_funct3;
          op_d.offset  = bus.req_addr[1:0];
          op_d.rd      = bus.req_rd;
          if (bad) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rd_d    = '0;
            resp_data_d  = '0;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = ~bus.req_is_load;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_be_d    = bus.req_is_load ? 4'hF : store_be;
            mem_wdata_d = store_wdata;
          end
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rd_d    = op_q.is_load ? op_q.rd : 5'd0;
          resp_data_d  = op_q.is_load ? load_data : 32'd0;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rd_d    = '0;
          resp_data_d  = '0;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level reference model, per-cycle
// compare process, directed scenarios with literal expectations and a randomized phase.
module tb_load_store_unit;
  localparam int TMO = 16;

  logic clk;
  logic rst;

  load_store_unit_if bus ();
  load_store_unit_if bus0 ();

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
  load_store_unit #(.TIMEOUT_CYCLES(0))   dut0 (.clk(clk), .rst(rst), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model expectations for the current cycle of the main DUT.
  bit          exp_ready;
  bit          exp_mreq;
  bit          exp_we;
  bit          exp_ld;
  logic [31:0] exp_addr;
  logic [31:0] exp_wd;
  logic [3:0]  exp_be;
  bit          exp_rv;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  bit          exp_err;

  // Observations recorded by the compare process for directed literal checks.
  int          mreq_total = 0;
  logic [31:0] seen_addr, seen_wd, seen_data;
  logic [3:0]  seen_be;
  logic        seen_we, seen_err;
  logic [4:0]  seen_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic bit f_bad(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (ld) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else    legal = (f3 <= 3'd2);
    if (!legal) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] f_be(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    if (ld) return 4'hF;
    if (f3 == 3'd0) return 4'(1 << a[1:0]);
    if (f3 == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_wd(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'd0) return {4{wd[7:0]}};
    if (f3 == 3'd1) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
    logic [31:0] w;
    w = rdata >> (8 * a[1:0]);
    case (f3)
      3'd0:    return w[7]  ? (32'hFFFFFF00 | {24'd0, w[7:0]})  : {24'd0, w[7:0]};
      3'd1:    return w[15] ? (32'hFFFF0000 | {16'd0, w[15:0]}) : {16'd0, w[15:0]};
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return rdata;
    endcase
  endfunction

  // Per-cycle comparison of the main DUT against the model, away from the active edge.
  always @(negedge clk) begin
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("mem_req", 32'(bus.mem_req), 32'(exp_mreq));
    if (exp_mreq) begin
      chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_be", 32'(bus.mem_be), 32'(exp_be));
      if (!exp_ld) chk("mem_wdata", bus.mem_wdata, exp_wd);
    end
    chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("resp_rd", 32'(bus.resp_rd), 32'(exp_rd));
      chk("resp_data", bus.resp_data, exp_data);
      chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
    end
    if (bus.mem_req) begin
      mreq_total++;
      seen_addr = bus.mem_addr;
      seen_wd   = bus.mem_wdata;
      seen_be   = bus.mem_be;
      seen_we   = bus.mem_we;
    end
    if (bus.resp_valid) begin
      seen_rd   = bus.resp_rd;
      seen_data = bus.resp_data;
      seen_err  = bus.resp_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise_req();
    bus.req_valid    = 1'($urandom);
    bus.req_is_load  = 1'($urandom);
    bus.req_is_store = 1'($urandom);
    bus.req_funct3   = 3'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    bus.req_rd       = 5'($urandom);
  endtask

  task automatic set_resp(input bit err, input logic [4:0] rd, input logic [31:0] data);
    exp_mreq = 1'b0;
    exp_rv   = 1'b1;
    exp_err  = err;
    exp_rd   = rd;
    exp_data = data;
  endtask

  // One complete transaction; ack_at = REQ cycle (1-based) carrying mem_ack, 0 = never.
  task automatic access(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input int ack_at, input logic [31:0] rdata, input int hold);
    int  c;
    bit  done;
    bit  eff_ld;
    eff_ld           = ld;
    bus.req_valid    = 1'b1;
    bus.req_is_load  = ld;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
    bus.mem_ack      = 1'($urandom);
    bus.mem_rdata    = $urandom;
    tick();
    bus.req_valid = 1'b0;
    bus.mem_ack   = 1'b0;
    if (!ld && !st) return;
    exp_ready = 1'b0;
    if (f_bad(eff_ld, f3, a)) begin
      set_resp(1'b1, 5'd0, 32'd0);
    end else begin
      exp_mreq = 1'b1;
      exp_we   = !eff_ld;
      exp_ld   = eff_ld;
      exp_addr = {a[31:2], 2'b00};
      exp_be   = f_be(eff_ld, f3, a);
      exp_wd   = f_wd(f3, wd);
      c        = 1;
      done     = 1'b0;
      while (!done) begin
        noise_req();
        bus.mem_ack   = (c == ack_at);
        bus.mem_rdata = (c == ack_at) ? rdata : $urandom;
        tick();
        bus.mem_ack = 1'b0;
        if (c == ack_at) begin
          set_resp(1'b0, eff_ld ? rd : 5'd0, eff_ld ? f_load(f3, a, rdata) : 32'd0);
          done = 1'b1;
        end else if (c == TMO) begin
          set_resp(1'b1, 5'd0, 32'd0);
          done = 1'b1;
        end
        c++;
      end
    end
    repeat (hold) begin
      noise_req();
      bus.mem_ack   = 1'($urandom);
      bus.mem_rdata = $urandom;
      tick();
    end
    bus.req_valid  = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    exp_rv    = 1'b0;
    exp_ready = 1'b1;
  endtask

  int base;

  initial begin
    rst = 1'b1;
    {bus.req_valid, bus.req_is_load, bus.req_is_store, bus.mem_ack, bus.resp_ready} = '0;
    {bus.req_funct3, bus.req_addr, bus.req_wdata, bus.req_rd, bus.mem_rdata} = '0;
    {bus0.req_valid, bus0.req_is_load, bus0.req_is_store, bus0.mem_ack, bus0.resp_ready} = '0;
    {bus0.req_funct3, bus0.req_addr, bus0.req_wdata, bus0.req_rd, bus0.mem_rdata} = '0;
    {exp_ready, exp_mreq, exp_we, exp_ld, exp_rv, exp_err} = '0;
    {exp_addr, exp_wd, exp_be, exp_rd, exp_data} = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst_resp_all", {bus.resp_data[26:0], bus.resp_rd}, 32'd0);
    chk("rst_resp_flags", {30'd0, bus.resp_valid, bus.resp_err}, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst       = 1'b0;
    exp_ready = 1'b1;
    tick();

    // LW with ack on the third REQ cycle and a two-cycle writeback stall
    base = mreq_total;
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd5, 3, 32'hDEADBEEF, 2);
    chk("t1_mreq_cycles", 32'(mreq_total - base), 32'd3);
    chk("t1_addr", seen_addr, 32'h100);
    chk("t1_be_we", {27'd0, seen_be, seen_we}, {27'd0, 4'hF, 1'b0});
    chk("t1_data", seen_data, 32'hDEADBEEF);
    chk("t1_rd_err", {26'd0, seen_rd, seen_err}, {26'd0, 5'd5, 1'b0});

    // Sub-word loads with sign and zero extension
    access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 5'd1, 1, 32'h80000000, 0);
    chk("t2_lb_addr", seen_addr, 32'h100);
    chk("t2_lb", seen_data, 32'hFFFFFF80);
    access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 5'd1, 2, 32'h80000000, 1);
    chk("t2_lbu", seen_data, 32'h00000080);
    access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 5'd2, 1, 32'h80010000, 0);
    chk("t2_lh", seen_data, 32'hFFFF8001);

    // SH to upper half
    access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd9, 2, 32'h0, 0);
    chk("t3_we_be", {27'd0, seen_be, seen_we}, {27'd0, 4'b1100, 1'b1});
    chk("t3_addr", seen_addr, 32'h200);
    chk("t3_wdata", seen_wd, 32'hABCDABCD);
    chk("t3_resp", {seen_data[25:0], seen_rd, seen_err}, 32'd0);

    // Misaligned and illegal accesses never reach the bus
    base = mreq_total;
    access(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 5'd4, 1, 32'h0, 1);
    chk("t4_lw_mis_err", {26'd0, seen_rd, seen_err}, 32'd1);
    access(1'b0, 1'b1, 3'b011, 32'h100, 32'h55, 5'd4, 1, 32'h0, 0);
    chk("t4_illegal_err", {26'd0, seen_rd, seen_err}, 32'd1);
    chk("t4_no_mreq", 32'(mreq_total - base), 32'd0);

    // Timeout, and ack on the last permitted cycle
    base = mreq_total;
    access(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 5'd6, 0, 32'h0, 0);
    chk("t5_mreq_cycles", 32'(mreq_total - base), 32'd16);
    chk("t5_err", 32'(seen_err), 32'd1);
    base = mreq_total;
    access(1'b1, 1'b0, 3'b010, 32'h404, 32'd0, 5'd6, 16, 32'h0BADF00D, 0);
    chk("t5_late_ack_cycles", 32'(mreq_total - base), 32'd16);
    chk("t5_late_ack_data", seen_data, 32'h0BADF00D);
    chk("t5_late_ack_err", 32'(seen_err), 32'd0);

    // Without a timeout the LSU waits for the bus indefinitely
    bus0.req_valid   = 1'b1;
    bus0.req_is_load = 1'b1;
    bus0.req_funct3  = 3'b010;
    bus0.req_addr    = 32'h40;
    bus0.req_rd      = 5'd7;
    tick();
    bus0.req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("t5_notmo_mreq", 32'(bus0.mem_req), 32'd1);
      chk("t5_notmo_rv", 32'(bus0.resp_valid), 32'd0);
      tick();
    end
    bus0.mem_ack   = 1'b1;
    bus0.mem_rdata = 32'h11223344;
    tick();
    bus0.mem_ack = 1'b0;
    chk("t5_notmo_resp", {bus0.resp_valid, bus0.resp_err, bus0.resp_rd},
        {30'd0, 1'b1, 1'b0, 5'd7} >> 0);
    chk("t5_notmo_data", bus0.resp_data, 32'h11223344);
    bus0.resp_ready = 1'b1;
    tick();
    bus0.resp_ready = 1'b0;
    chk("t5_notmo_done", 32'(bus0.resp_valid), 32'd0);

    // Reset while a load is in flight; a later ack is stray
    bus.req_valid    = 1'b1;
    bus.req_is_load  = 1'b1;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'b010;
    bus.req_addr     = 32'h300;
    bus.req_rd       = 5'd3;
    tick();
    bus.req_valid = 1'b0;
    exp_ready = 1'b0;
    exp_mreq  = 1'b1;
    exp_we    = 1'b0;
    exp_ld    = 1'b1;
    exp_addr  = 32'h300;
    exp_be    = 4'hF;
    tick();
    rst      = 1'b1;
    exp_mreq = 1'b0;
    #1;
    chk("t6_mreq_async", 32'(bus.mem_req), 32'd0);
    chk("t6_ready_in_rst", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_ready = 1'b1;
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    tick();
    bus.mem_ack = 1'b0;
    chk("t6_stray_rv", 32'(bus.resp_valid), 32'd0);
    chk("t6_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) tick();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int          r;
      bit          ld, st;
      logic [2:0]  f3;
      logic [31:0] a;
      r  = $urandom_range(0, 9);
      ld = (r >= 1 && r <= 4) || r == 9;
      st = (r >= 5);
      if ($urandom_range(0, 9) < 7) begin
        r  = $urandom_range(0, 4);
        f3 = (r < 3) ? 3'(r) : 3'(r + 1);
      end else begin
        f3 = 3'($urandom);
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      access(ld, st, f3, a, $urandom, 5'($urandom), $urandom_range(0, 18), $urandom,
             $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
